// File: rtl/scan_chain_ctrl.sv
// Scan sequencer for an SDFF_X1 chain: serial load, one capture cycle, serial unload.
// Optional expected-response compare is built when SCAN_CMP_EN is defined.
module scan_chain_ctrl #(
  parameter int CHAIN_LEN = 8,
  parameter int CNT_W     = 4
) (
  input  logic                 CK,
  input  logic                 RST,
  input  logic                 START,
  input  logic [CHAIN_LEN-1:0] PAT_IN,
  input  logic                 SO,
  output logic                 SE,
  output logic                 SI,
  output logic [CHAIN_LEN-1:0] RESP_OUT,
  output logic                 BUSY,
  output logic                 DONE
`ifdef SCAN_CMP_EN
  ,
  input  logic [CHAIN_LEN-1:0] EXP_IN,
  output logic                 MISMATCH
`endif
);

  localparam int              ACC_W    = CHAIN_LEN - 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CHAIN_LEN - 1);

  typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_CAPTURE, S_UNLOAD} state_t;

  state_t               state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [ACC_W-1:0]     pat_q, pat_d;   // pattern bits 1..N-1 still to be sent
  logic [ACC_W-1:0]     acc_q, acc_d;   // first N-1 unloaded bits
  logic                 se_q, se_d;
  logic                 si_q, si_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;
  logic [CHAIN_LEN-1:0] resp_q, resp_d;
  logic [CHAIN_LEN-1:0] unload_word;

`ifdef SCAN_CMP_EN
  logic [CHAIN_LEN-1:0] exp_q, exp_d;
  logic                 mis_q, mis_d;
`endif

  // The last unload edge completes the word with the live SO bit.
  assign unload_word = {SO, acc_q};

  always_ff @(posedge CK or posedge RST) begin
    if (RST) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      pat_q   <= '0;
      acc_q   <= '0;
      se_q    <= 1'b0;
      si_q    <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      resp_q  <= '0;
`ifdef SCAN_CMP_EN
      exp_q   <= '0;
      mis_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      pat_q   <= pat_d;
      acc_q   <= acc_d;
      se_q    <= se_d;
      si_q    <= si_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      resp_q  <= resp_d;
`ifdef SCAN_CMP_EN
      exp_q   <= exp_d;
      mis_q   <= mis_d;
`endif
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    pat_d   = pat_q;
    acc_d   = acc_q;
    se_d    = se_q;
    si_d    = si_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    resp_d  = resp_q;
`ifdef SCAN_CMP_EN
    exp_d   = exp_q;
    mis_d   = mis_q;
`endif
    case (state_q)
      S_IDLE: begin
        se_d   = 1'b0;
        si_d   = 1'b0;
        busy_d = 1'b0;
        if (START) begin
          state_d = S_SHIFT;
          pat_d   = PAT_IN[CHAIN_LEN-1:1];
          si_d    = PAT_IN[0];
          se_d    = 1'b1;
          busy_d  = 1'b1;
          cnt_d   = '0;
`ifdef SCAN_CMP_EN
          exp_d   = EXP_IN;
`endif
        end
      end
      S_SHIFT: begin
        if (cnt_q == CNT_LAST) begin
          state_d = S_CAPTURE;
          se_d    = 1'b0;
          si_d    = 1'b0;
        end else begin
          si_d  = pat_q[0];
          pat_d = pat_q >> 1;
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_CAPTURE: begin
        state_d = S_UNLOAD;
        se_d    = 1'b1;
        cnt_d   = '0;
      end
      S_UNLOAD: begin
        if (cnt_q == CNT_LAST) begin
          state_d = S_IDLE;
          resp_d  = unload_word;
          done_d  = 1'b1;
          busy_d  = 1'b0;
          se_d    = 1'b0;
`ifdef SCAN_CMP_EN
          mis_d   = |(unload_word ^ exp_q);
`endif
        end else begin
          acc_d = ACC_W'(unload_word >> 1);
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign SE       = se_q;
  assign SI       = si_q;
  assign RESP_OUT = resp_q;
  assign BUSY     = busy_q;
  assign DONE     = done_q;
`ifdef SCAN_CMP_EN
  assign MISMATCH = mis_q;
`endif

endmodule

// File: tb/tb_scan_chain_ctrl.sv
// Bench for scan_chain_ctrl driving a behavioural SDFF_X1 chain (hold / invert / zero D).
module tb_scan_chain_ctrl;
  localparam int N = 8;

  logic         CK = 1'b0;
  logic         RST, START, SO;
  logic [N-1:0] PAT_IN;
  logic         SE, SI, BUSY, DONE;
  logic [N-1:0] RESP_OUT;
`ifdef SCAN_CMP_EN
  logic [N-1:0] EXP_IN;
  logic         MISMATCH;
  logic [N-1:0] exp_v = '0;
  logic         mis_q[$];
`endif

  always #5 CK = ~CK;

  scan_chain_ctrl #(.CHAIN_LEN(N), .CNT_W(4)) dut (
    .CK(CK), .RST(RST), .START(START), .PAT_IN(PAT_IN), .SO(SO),
    .SE(SE), .SI(SI), .RESP_OUT(RESP_OUT), .BUSY(BUSY), .DONE(DONE)
`ifdef SCAN_CMP_EN
    , .EXP_IN(EXP_IN), .MISMATCH(MISMATCH)
`endif
  );

  // Chain model: position 0 is fed by SI, SO is the last flop.
  int           mode = 0;
  logic [N-1:0] chain = '0;
  assign SO = chain[N-1];
  always @(posedge CK)
    chain <= SE ? {chain[N-2:0], SI} :
             (mode == 0) ? chain : (mode == 1) ? ~chain : '0;

  int           n_cmp = 0, n_err = 0;
  logic [N-1:0] exp_q[$];

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Scoreboard: every DONE must retire one pending expectation.
  always @(negedge CK) begin
    if (DONE === 1'b1) begin
      chk("sb_pending", exp_q.size() > 0, 1);
      if (exp_q.size() > 0) chk("sb_resp", RESP_OUT, exp_q.pop_front());
`ifdef SCAN_CMP_EN
      if (mis_q.size() > 0) chk("sb_mismatch", MISMATCH, mis_q.pop_front());
`endif
    end
  end

  function automatic logic [N-1:0] model(logic [N-1:0] pat, int md);
    return (md == 0) ? pat : (md == 1) ? ~pat : '0;
  endfunction

  task automatic push_exp(logic [N-1:0] pat, int md);
    exp_q.push_back(model(pat, md));
`ifdef SCAN_CMP_EN
    EXP_IN = exp_v;
    mis_q.push_back(|(model(pat, md) ^ exp_v));
`endif
  endtask

  // One full sequence; restart_at >= 1 pulses START so edge restart_at samples it.
  task automatic run(logic [N-1:0] pat, int md, int restart_at);
    logic se_log[0:2*N+1];
    logic si_log[0:2*N+1];
    logic bz_log[0:2*N+1];
    logic dn_log[0:2*N+1];
    logic [N-1:0] si_vec;
    int busy_cnt, se_low, done_cnt, done_idx;
    mode = md;
    PAT_IN = pat;
    START = 1'b1;
    push_exp(pat, md);
    for (int c = 0; c <= 2*N+1; c++) begin
      @(negedge CK);
      if (c == 0) begin START = 1'b0; PAT_IN = N'($urandom); end
      se_log[c] = SE; si_log[c] = SI; bz_log[c] = BUSY; dn_log[c] = DONE;
      if (c == restart_at - 1) START = 1'b1;
      if (c == restart_at) START = 1'b0;
    end
    busy_cnt = 0; se_low = 0; done_cnt = 0; done_idx = -1;
    for (int c = 0; c <= 2*N+1; c++) begin
      if (bz_log[c]) busy_cnt++;
      if (c <= 2*N && !se_log[c]) se_low++;
      if (dn_log[c]) begin done_cnt++; if (done_idx < 0) done_idx = c; end
    end
    for (int k = 0; k < N; k++) si_vec[k] = si_log[k];
    chk("busy_cycles", busy_cnt, 2*N+1);
    chk("done_count", done_cnt, 1);
    chk("done_cycle", done_idx, 2*N+1);
    chk("se_low_cycles", se_low, 1);
    chk("se_capture", se_log[N], 0);
    chk("se_idle", se_log[2*N+1], 0);
    chk("si_seq", si_vec, pat);
    chk("si_after_shift", si_log[N], 0);
    chk("resp_hold", RESP_OUT, model(pat, md));
  endtask

  initial begin
    int d1, d2, dcnt, busy_after, seen;
    RST = 1'b1; START = 1'b0; PAT_IN = '0;
`ifdef SCAN_CMP_EN
    EXP_IN = '0;
`endif
    repeat (2) @(negedge CK);
    chk("rst_se", SE, 0);
    chk("rst_si", SI, 0);
    chk("rst_busy", BUSY, 0);
    chk("rst_done", DONE, 0);
    chk("rst_resp", RESP_OUT, 0);
    RST = 1'b0;
    @(negedge CK);

    run(8'hA5, 0, -1);
    run(8'h3C, 1, -1);
    run(8'hFF, 2, -1);
    run(8'h69, 0, 5);

    // Abort mid-shift.
    mode = 0; PAT_IN = 8'hC6; START = 1'b1;
    push_exp(8'hC6, 0);
    @(negedge CK); START = 1'b0;
    repeat (4) @(negedge CK);
    chk("pre_rst_busy", BUSY, 1);
    RST = 1'b1;
    #1;
    chk("abort_se", SE, 0);
    chk("abort_si", SI, 0);
    chk("abort_busy", BUSY, 0);
    chk("abort_done", DONE, 0);
    chk("abort_resp", RESP_OUT, 0);
    exp_q.delete();
`ifdef SCAN_CMP_EN
    mis_q.delete();
`endif
    @(negedge CK); RST = 1'b0;
    seen = 0;
    repeat (2*N+4) begin @(negedge CK); if (DONE) seen++; end
    chk("abort_no_done", seen, 0);
    run(8'h81, 1, -1);

    // START held high: back-to-back sequences every 2N+2 cycles.
    mode = 0; PAT_IN = 8'h96; START = 1'b1;
    push_exp(8'h96, 0); push_exp(8'h96, 0);
    d1 = -1; d2 = -1; dcnt = 0; busy_after = 0;
    for (int cyc = 0; cyc < 60 && d2 < 0; cyc++) begin
      @(negedge CK);
      if (d1 >= 0 && cyc == d1 + 1) busy_after = BUSY;
      if (DONE) begin
        dcnt++;
        if (d1 < 0) d1 = cyc; else begin d2 = cyc; START = 1'b0; end
      end
    end
    START = 1'b0;
    chk("held_done_count", dcnt, 2);
    chk("held_gap", d2 - d1, 2*N+2);
    chk("held_busy_restart", busy_after, 1);
    @(negedge CK);
    chk("held_stop_busy", BUSY, 0);
    exp_q.delete();

`ifdef SCAN_CMP_EN
    mis_q.delete();
    exp_v = 8'h5A;
    run(8'h5A, 0, -1);
    chk("cmp_match", MISMATCH, 0);
    exp_v = 8'h5B;
    run(8'h5A, 0, -1);
    chk("cmp_diff", MISMATCH, 1);
`endif

    repeat (2) @(negedge CK);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
